bird_sprite_renderer: RTL and testbench
=======================================

BIRD_SPRITE_RENDERER -- requirements
Module: bird_sprite_renderer

Interface
REQ-001 SHALL have parameter SPR_W, default 18, meaning sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 12, meaning sprite height in pixels.
REQ-003 SHALL have parameter BIRD_X, default 320, meaning screen column of the sprite's anchor column.
REQ-004 SHALL have parameter NUM_FRAMES, default 3, meaning number of wing-animation frames.
REQ-005 SHALL have parameter FLAP_PERIOD, default 6, meaning video frames per animation step (must be 1 or more).
REQ-006 SHALL have parameter INIT_Y, default 240, meaning bird_y value loaded at reset.
REQ-007 SHALL have port clock, input, width 1, meaning the single system clock.
REQ-008 SHALL have port reset, input, width 1, meaning synchronous active-high reset.
REQ-009 SHALL have port row, input, width 10, meaning current VGA row.
REQ-010 SHALL have port col, input, width 10, meaning current VGA column.
REQ-011 SHALL have port bird_y, input, width 10, meaning bird anchor row from the game logic.
REQ-012 SHALL have port frame_start, input, width 1, meaning one-cycle pulse at the start of vertical blank.
REQ-013 SHALL have port flapping, input, width 1, meaning animation is enabled.
REQ-014 SHALL have port dead, input, width 1, meaning the bird is dead: animation frozen, sprite tinted.
REQ-015 SHALL have ports bg_red, bg_green and bg_blue, each input, width 8, meaning background colour for the current pixel.
REQ-016 SHALL have ports red, green and blue, each output, width 8, meaning composited pixel colour.
REQ-017 SHALL have port bird_px, output, width 1, meaning the output pixel is an opaque bird pixel, for collision logic.

Function
REQ-018 SHALL sample bird_y into y_q only on cycles where frame_start=1, so the sprite never tears mid-frame.
REQ-019 SHALL count frame_start pulses in flap_cnt; on reaching FLAP_PERIOD-1, flap_cnt SHALL wrap to 0 and anim SHALL advance by one modulo NUM_FRAMES (NUM_FRAMES-1 wraps to 0).
REQ-020 SHALL hold flap_cnt and anim unchanged while flapping=0.
REQ-021 SHALL clear flap_cnt to 0 and hold anim at 0 while dead=1; dead SHALL take priority over flapping.
REQ-022 SHALL treat the sprite window as rows y_q-SPR_H/2 through y_q-SPR_H/2+SPR_H-1 and columns BIRD_X-SPR_W/2 through BIRD_X-SPR_W/2+SPR_W-1.
REQ-023 SHALL compute window bounds in signed 12-bit arithmetic, so a sprite partially above row 0 is clipped with no wrap to the screen bottom.
REQ-024 SHALL compute, in stage 1, in_win plus the ROM address anim*SPR_W*SPR_H + (row-top)*SPR_W + (col-left).
REQ-025 SHALL perform, in stage 2, a synchronous ROM read returning a 3-bit palette index.
REQ-026 SHALL delay in_win and the bg colour to stage 2 alongside the ROM read.
REQ-027 SHALL make outputs registered with a fixed latency of 2 cycles from row/col/bg_* to red/green/blue/bird_px.
REQ-028 SHALL output bg_* and bird_px=0 when out of window or index=TRANSPARENT; otherwise output the palette colour and bird_px=1.
REQ-029 SHALL, when dead=1, output each opaque pixel as {red, green>>1, blue>>1}.
REQ-030 SHALL, when frame_start and a pixel occur in the same cycle, render that pixel using the old y_q and old anim.

Reset
REQ-031 SHALL, on reset, load INIT_Y into y_q and clear flap_cnt, anim, all pipeline registers, red, green, blue and bird_px to 0.
REQ-032 SHALL treat reset asserted mid-frame as abandoning in-flight pixels; outputs are 0 on the cycle after reset and valid again 2 cycles after deassertion.

Structure
REQ-033 SHALL place color_t (TRANSPARENT, BLACK, RED, ORANGE, YELLOW, WHITE, 3 bits) and the per-colour 24-bit RGB constants in package bird_gfx_pkg.
REQ-034 SHALL use exactly one sub-module, bird_sprite_rom: NUM_FRAMES*SPR_W*SPR_H by 3 bits, one-cycle synchronous read, contents from a memory-init file.

Verification
REQ-035 SHALL verify that after reset with no frame_start, pixel (240,320) appears 2 cycles later as the frame-0 anchor colour, and pixel (0,0) appears as bg_* with bird_px=0.
REQ-036 SHALL verify that changing bird_y from 240 to 100 mid-frame leaves the output unchanged until the next frame_start, after which the sprite is drawn at row 100.
REQ-037 SHALL verify that with flapping=1 and FLAP_PERIOD=6, anim steps 0 to 1 after 6 pulses, 1 to 2 after 12, and 2 to 0 after 18.
REQ-038 SHALL verify that with bird_y=3, rows 0 to 8 show the sprite, no pixel in rows 470 to 479 shows the sprite, and nothing is out of range.
REQ-039 SHALL verify that with dead=1, anim is forced to 0, an opaque pixel with WHITE index outputs {FF,7F,7F}, and transparent pixels still pass bg_*.
REQ-040 SHALL verify that frame_start coinciding with a window pixel uses the old y_q, and reset asserted mid-window forces 0 outputs on the next cycle.

Source files
------------

// File: rtl/bird_gfx_pkg.sv
// Shared graphics definitions for the bird sprite: palette index type,
// 24-bit RGB constants per palette entry, and the procedural sprite art
// used as the ROM image.
package bird_gfx_pkg;

  typedef enum logic [2:0] {
    TRANSPARENT = 3'd0,
    BLACK       = 3'd1,
    RED         = 3'd2,
    ORANGE      = 3'd3,
    YELLOW      = 3'd4,
    WHITE       = 3'd5
  } color_t;

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_RED    = 24'hFF0000;
  localparam logic [23:0] RGB_ORANGE = 24'hFF8000;
  localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
  localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;

  function automatic logic [23:0] palette_rgb(input color_t c);
    case (c)
      BLACK:   return RGB_BLACK;
      RED:     return RGB_RED;
      ORANGE:  return RGB_ORANGE;
      YELLOW:  return RGB_YELLOW;
      WHITE:   return RGB_WHITE;
      default: return 24'h000000;
    endcase
  endfunction

  // Sprite image: yellow body, white eye with black pupil, orange beak,
  // and a white wing whose rows move down by two per animation frame.
  // Row 0 and the outer columns are transparent.
  function automatic color_t bird_pixel(input int unsigned frame,
                                        input int unsigned r,
                                        input int unsigned c,
                                        input int unsigned w,
                                        input int unsigned h);
    if (r == 0 || c == 0 || c == w - 1)                          return TRANSPARENT;
    if (r == 3 && c == w - 6)                                    return WHITE;
    if (r == 3 && c == w - 5)                                    return BLACK;
    if (r >= h / 2 - 1 && r <= h / 2 && c >= w - 3 && c <= w - 2) return ORANGE;
    if (r >= 3 + 2 * frame && r <= 4 + 2 * frame && c >= 3 && c <= 7) return WHITE;
    if (c >= 1 && c <= w - 4)                                    return YELLOW;
    return TRANSPARENT;
  endfunction

endpackage

// File: rtl/bird_sprite_rom.sv
// Sprite palette-index ROM, NUM_FRAMES*SPR_W*SPR_H entries of 3 bits.
// Ports: clock/reset (sync, active high), addr (linear frame/row/col
// address), idx (registered palette index, one-cycle read latency).
module bird_sprite_rom
  import bird_gfx_pkg::*;
#(
  parameter int SPR_W      = 18,
  parameter int SPR_H      = 12,
  parameter int NUM_FRAMES = 3,
  parameter int ADDR_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        idx
);

  localparam int DEPTH = NUM_FRAMES * SPR_W * SPR_H;

  logic [2:0] rom_mem [DEPTH];
  logic [2:0] idx_d, idx_q;

  // The init image is elaborated from the package art function so the
  // table stays constant and maps onto a ROM.
  for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frame
    for (genvar r = 0; r < SPR_H; r++) begin : g_row
      for (genvar c = 0; c < SPR_W; c++) begin : g_col
        assign rom_mem[f*SPR_W*SPR_H + r*SPR_W + c] =
          bird_pixel(f, r, c, SPR_W, SPR_H);
      end
    end
  end

  always_comb begin
    idx_d = '0;
    if (int'(addr) < DEPTH) idx_d = rom_mem[addr];
  end

  always_ff @(posedge clock) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign idx = idx_q;

endmodule

// File: rtl/bird_sprite_renderer.sv
// Composites an animated bird sprite over a VGA background stream.
// Ports: clock/reset (sync, active high); row/col current VGA position;
// bird_y anchor row (latched on frame_start); flapping/dead animation
// controls; bg_* background colour; red/green/blue composited output
// and bird_px opaque-bird flag, both 2 cycles after row/col/bg_*.
module bird_sprite_renderer
  import bird_gfx_pkg::*;
#(
  parameter int SPR_W       = 18,
  parameter int SPR_H       = 12,
  parameter int BIRD_X      = 320,
  parameter int NUM_FRAMES  = 3,
  parameter int FLAP_PERIOD = 6,
  parameter int INIT_Y      = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic [9:0] bird_y,
  input  logic       frame_start,
  input  logic       flapping,
  input  logic       dead,
  input  logic [7:0] bg_red,
  input  logic [7:0] bg_green,
  input  logic [7:0] bg_blue,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       bird_px
);

  localparam int DEPTH = NUM_FRAMES * SPR_W * SPR_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AN_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int FC_W  = (FLAP_PERIOD > 1) ? $clog2(FLAP_PERIOD) : 1;

  localparam logic signed [11:0] HALF_H = 12'(SPR_H / 2);
  localparam logic signed [11:0] H_S    = 12'(SPR_H);
  localparam logic signed [11:0] W_S    = 12'(SPR_W);
  localparam logic signed [11:0] LEFT_S = 12'(BIRD_X - SPR_W / 2);

  logic [9:0]      y_d, y_q;
  logic [FC_W-1:0] flap_cnt_d, flap_cnt_q;
  logic [AN_W-1:0] anim_d, anim_q, anim_eff;

  logic signed [11:0] row_s, col_s, top_s;
  logic [11:0]        dr, dc;
  logic               in_win_d, in_win_q;
  logic [AW-1:0]      rom_addr;
  logic [2:0]         rom_idx;
  logic [23:0]        bg_d, bg_q;
  logic               dead_s_d, dead_s_q;

  color_t      pix_idx;
  logic        opaque;
  logic [23:0] rgb;
  logic [23:0] pix_d, pix_q;
  logic        bird_px_d, bird_px_q;

  // Frame-synchronous state: position and animation step.
  always_comb begin
    y_d        = frame_start ? bird_y : y_q;
    flap_cnt_d = flap_cnt_q;
    anim_d     = anim_q;
    if (dead) begin
      flap_cnt_d = '0;
      anim_d     = '0;
    end else if (flapping && frame_start) begin
      if (flap_cnt_q == FC_W'(FLAP_PERIOD - 1)) begin
        flap_cnt_d = '0;
        anim_d     = (anim_q == AN_W'(NUM_FRAMES - 1)) ? '0 : anim_q + 1'b1;
      end else begin
        flap_cnt_d = flap_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: window test in signed arithmetic so a sprite above row 0 clips
  // instead of wrapping; the address feeds the ROM's registered read.
  always_comb begin
    anim_eff = dead ? '0 : anim_q;
    row_s    = $signed({2'b00, row});
    col_s    = $signed({2'b00, col});
    top_s    = $signed({2'b00, y_q}) - HALF_H;
    in_win_d = (row_s >= top_s) && (row_s < top_s + H_S) &&
               (col_s >= LEFT_S) && (col_s < LEFT_S + W_S);
    dr       = row_s - top_s;
    dc       = col_s - LEFT_S;
    rom_addr = in_win_d ? AW'(32'(anim_eff) * 32'(SPR_W * SPR_H) +
                              32'(dr) * 32'(SPR_W) + 32'(dc))
                        : '0;
    bg_d     = {bg_red, bg_green, bg_blue};
    dead_s_d = dead;
  end

  bird_sprite_rom #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .NUM_FRAMES (NUM_FRAMES),
    .ADDR_W     (AW)
  ) u_rom (
    .clock (clock),
    .reset (reset),
    .addr  (rom_addr),
    .idx   (rom_idx)
  );

  // Stage 2: palette lookup, dead tint, composite over background.
  always_comb begin
    pix_idx = color_t'(rom_idx);
    opaque  = in_win_q && (pix_idx != TRANSPARENT);
    rgb     = palette_rgb(pix_idx);
    if (dead_s_q) rgb = {rgb[23:16], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
    pix_d     = opaque ? rgb : bg_q;
    bird_px_d = opaque;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_q        <= 10'(INIT_Y);
      flap_cnt_q <= '0;
      anim_q     <= '0;
      in_win_q   <= 1'b0;
      bg_q       <= '0;
      dead_s_q   <= 1'b0;
      pix_q      <= '0;
      bird_px_q  <= 1'b0;
    end else begin
      y_q        <= y_d;
      flap_cnt_q <= flap_cnt_d;
      anim_q     <= anim_d;
      in_win_q   <= in_win_d;
      bg_q       <= bg_d;
      dead_s_q   <= dead_s_d;
      pix_q      <= pix_d;
      bird_px_q  <= bird_px_d;
    end
  end

  assign red     = pix_q[23:16];
  assign green   = pix_q[15:8];
  assign blue    = pix_q[7:0];
  assign bird_px = bird_px_q;

endmodule

// File: tb/tb_bird_sprite_renderer.sv
// Directed bench for bird_sprite_renderer with hand-computed pixels.
// Sprite at y=240: top row 234, left col 311. Art offsets (row,col):
// eye (3,12) white, pupil (3,13) black, beak rows 5-6 cols 15-16 orange,
// wing cols 3-7 rows 3-4 / 5-6 / 7-8 for frames 0/1/2, body yellow
// cols 1-14 rows 1-11, row 0 and cols 0,17 transparent.
module tb_bird_sprite_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] row, col, bird_y;
  logic       frame_start, flapping, dead;
  logic [7:0] bg_red, bg_green, bg_blue;
  logic [7:0] red, green, blue;
  logic       bird_px;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [24:0] E_YEL   = {1'b1, 24'hFFFF00};
  localparam logic [24:0] E_WHT   = {1'b1, 24'hFFFFFF};
  localparam logic [24:0] E_BLK   = {1'b1, 24'h000000};
  localparam logic [24:0] E_ORG   = {1'b1, 24'hFF8000};
  localparam logic [24:0] E_BG    = {1'b0, 24'h123456};
  localparam logic [24:0] E_BG2   = {1'b0, 24'hABCDEF};
  localparam logic [24:0] E_ZERO  = 25'd0;
  localparam logic [24:0] E_DWHT  = {1'b1, 24'hFF7F7F};
  localparam logic [24:0] E_DYEL  = {1'b1, 24'hFF7F00};

  bird_sprite_renderer #(
    .SPR_W       (18),
    .SPR_H       (12),
    .BIRD_X      (320),
    .NUM_FRAMES  (3),
    .FLAP_PERIOD (6),
    .INIT_Y      (240)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .bird_y      (bird_y),
    .frame_start (frame_start),
    .flapping    (flapping),
    .dead        (dead),
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .bird_px     (bird_px)
  );

  always #5 clock = ~clock;

  function automatic logic [24:0] obs_now();
    return {bird_px, red, green, blue};
  endfunction

  task automatic check_now(input string tag, input logic [24:0] exp);
    logic [24:0] obs;
    obs = obs_now();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a pixel, wait the two-cycle latency, compare.
  task automatic check_px(input string tag, input int r, input int c,
                          input logic [24:0] exp);
    row = 10'(r);
    col = 10'(c);
    @(posedge clock);
    @(posedge clock);
    #1;
    check_now(tag, exp);
  endtask

  task automatic pulse_frame(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(posedge clock);
      #1;
      frame_start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; row = '0; col = '0; bird_y = 10'd240;
    frame_start = 1'b0; flapping = 1'b0; dead = 1'b0;
    bg_red = 8'h12; bg_green = 8'h34; bg_blue = 8'h56;
    repeat (3) @(posedge clock);
    #1;
    check_now("reset_outputs", E_ZERO);
    reset = 1'b0;

    // Reset state: y=INIT_Y, frame 0, no frame_start yet.
    check_px("anchor_240_320", 240, 320, E_YEL);
    check_px("origin_bg", 0, 0, E_BG);
    check_px("wing_f0", 238, 316, E_WHT);
    check_px("eye", 237, 323, E_WHT);
    check_px("pupil", 237, 324, E_BLK);
    check_px("beak", 239, 326, E_ORG);
    check_px("top_row_transparent", 234, 320, E_BG);
    check_px("left_outside", 240, 310, E_BG);
    check_px("right_col_transparent", 240, 328, E_BG);
    check_px("bottom_row_in", 245, 320, E_YEL);
    check_px("below_window", 246, 320, E_BG);
    bg_red = 8'hAB; bg_green = 8'hCD; bg_blue = 8'hEF;
    check_px("bg_passthrough", 10, 10, E_BG2);
    bg_red = 8'h12; bg_green = 8'h34; bg_blue = 8'h56;

    // bird_y change mid-frame takes effect only at frame_start.
    bird_y = 10'd100;
    check_px("midframe_old_y", 240, 320, E_YEL);
    check_px("midframe_new_row_bg", 100, 320, E_BG);
    pulse_frame(1);
    check_px("newframe_row100", 100, 320, E_YEL);
    check_px("newframe_row240_bg", 240, 320, E_BG);

    // frame_start coinciding with a window pixel uses the old y.
    bird_y = 10'd240;
    row = 10'd100; col = 10'd320; frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
    @(posedge clock);
    #1;
    check_now("coincident_old_y", E_YEL);
    check_px("after_coincident_new_y", 240, 320, E_YEL);
    check_px("after_coincident_old_bg", 100, 320, E_BG);

    // Animation: 6 pulses per step, 3 frames.
    flapping = 1'b1;
    pulse_frame(5);
    check_px("anim0_after5", 238, 316, E_WHT);
    pulse_frame(1);
    check_px("anim1_f0wing_gone", 238, 316, E_YEL);
    check_px("anim1_wing", 240, 316, E_WHT);
    flapping = 1'b0;
    pulse_frame(10);
    check_px("hold_anim1", 240, 316, E_WHT);
    flapping = 1'b1;
    pulse_frame(6);
    check_px("anim2_wing", 242, 316, E_WHT);
    check_px("anim2_f1wing_gone", 240, 316, E_YEL);
    pulse_frame(6);
    check_px("anim_wrap0", 238, 316, E_WHT);
    check_px("anim_wrap0_f2gone", 242, 316, E_YEL);
    flapping = 1'b0;

    // Top clipping at bird_y=3: window rows -3..8.
    bird_y = 10'd3;
    pulse_frame(1);
    for (int r = 0; r <= 8; r++) check_px("top_clip_in", r, 320, E_YEL);
    check_px("top_clip_row9", 9, 320, E_BG);
    for (int r = 470; r <= 479; r++) check_px("no_wrap_bottom", r, 320, E_BG);

    // Dead: anim forced to frame 0, opaque pixels tinted.
    bird_y = 10'd240;
    pulse_frame(1);
    flapping = 1'b1;
    pulse_frame(6);
    check_px("pre_dead_anim1", 238, 316, E_YEL);
    dead = 1'b1;
    check_px("dead_wing_f0_tint", 238, 316, E_DWHT);
    check_px("dead_eye_tint", 237, 323, E_DWHT);
    check_px("dead_body_tint", 240, 320, E_DYEL);
    check_px("dead_bg", 0, 0, E_BG);
    check_px("dead_transparent_bg", 234, 320, E_BG);
    pulse_frame(8);
    check_px("dead_frozen", 238, 316, E_DWHT);
    dead = 1'b0;
    flapping = 1'b0;
    check_px("revived_anim0", 238, 316, E_WHT);

    // Reset mid-window: pipeline abandoned, outputs zero next cycle.
    row = 10'd240; col = 10'd320;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_now("reset_midwindow_zero", E_ZERO);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_now("post_reset_first_zero", E_ZERO);
    @(posedge clock);
    #1;
    check_now("post_reset_valid", E_YEL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
